// File: rtl/flash_resp_pkg.sv
// flash_resp_pkg: shared types and constants for flash_read_responder.
//   resp_state_t        - responder FSM states
//   CNT_W               - width of the shared wait/latency down-counter
//   FLASH_RESP_BAD_DATA - word returned for an out-of-range read
//                         (used only when FLASH_RESP_ADDR_CHK_EN is defined)
package flash_resp_pkg;

  localparam int CNT_W = 4;

  localparam logic [31:0] FLASH_RESP_BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCEPT,
    FETCH,
    RESP
  } resp_state_t;

endpackage

// File: rtl/flash_resp_if.sv
// flash_resp_if: Avalon-MM read slave signals plus the synchronous memory
// port of the responder, bundled together.
//   slave  modport : responder side (drives waitrequest/readdata/valid and
//                    the memory address/strobe, receives request and mem_q)
//   master modport : initiator + memory side (the opposite directions)
interface flash_resp_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              s_read;
  logic [ADDR_W-1:0] s_address;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  s_read, s_address, mem_q,
    output s_waitrequest, s_readdata, s_readdatavalid, mem_addr, mem_rden
  );

  modport master (
    output s_read, s_address, mem_q,
    input  s_waitrequest, s_readdata, s_readdatavalid, mem_addr, mem_rden
  );
endinterface

// File: rtl/flash_resp_delay_cnt.sv
// flash_resp_delay_cnt: loadable down-counter, saturating at zero.
//   inclk    - clock, rising edge
//   reset    - asynchronous, active-low
//   load     - load load_val this cycle (has priority over counting)
//   load_val - value to load
//   value    - current count
//   zero     - count is zero
// The counter decrements every cycle while non-zero; the owner only looks
// at it in the states that use it, so no separate enable is needed.
module flash_resp_delay_cnt
  import flash_resp_pkg::*;
(
  input  logic             inclk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset)     value <= '0;
    else if (load)  value <= load_val;
    else if (!zero) value <= value - 1'b1;
  end

endmodule

// File: rtl/flash_read_responder.sv
// flash_read_responder: Avalon-MM read-only slave in front of a synchronous
// on-chip memory holding a flash image. Inserts WAIT_CYCLES wait states,
// issues one memory read, and returns the word with a one-cycle valid pulse.
//   inclk  - clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - flash_resp_if.slave (s_read/s_address in, s_waitrequest,
//            s_readdata, s_readdatavalid out; mem_addr/mem_rden out, mem_q in)
//   rd_err - only with FLASH_RESP_ADDR_CHK_EN: pulses with s_readdatavalid
//            when the read address was >= MEM_DEPTH
// Optional feature macro: FLASH_RESP_ADDR_CHK_EN (address range check).
// Request-to-valid latency is WAIT_CYCLES + MEM_LAT + 3 cycles.
module flash_read_responder
  import flash_resp_pkg::*;
#(
  parameter int     ADDR_W      = 23,
  parameter int     DATA_W      = 32,
  parameter int     WAIT_CYCLES = 2,
  parameter int     MEM_LAT     = 1,
  parameter longint MEM_DEPTH   = longint'(1) << ADDR_W
) (
  input  logic          inclk,
  input  logic          reset,
  flash_resp_if.slave   bus
`ifdef FLASH_RESP_ADDR_CHK_EN
  ,
  output logic          rd_err
`endif
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("MEM_LAT must be in 1..4");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("MEM_DEPTH must be in 1..2**ADDR_W");
  end

  // WAIT lasts WAIT_CYCLES cycles: the counter leaves WAIT when it reads
  // zero, so it is loaded one short. FETCH lasts MEM_LAT+1 cycles because
  // mem_rden is registered: mem_q is valid in the cycle the counter hits 0.
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(MEM_LAT);

  resp_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rden_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cnt_value_unused;
  logic              cnt_zero;
  logic              launch;
  logic              capture;
  logic              bad_addr;

`ifdef FLASH_RESP_ADDR_CHK_EN
  logic err_q;
  assign bad_addr = ({{(64-ADDR_W){1'b0}}, addr_q} >= 64'(MEM_DEPTH));
  assign rd_err   = (state_q == RESP) && err_q;
`else
  assign bad_addr = 1'b0;
`endif

  flash_resp_delay_cnt u_cnt (
    .inclk    (inclk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .value    (cnt_value_unused),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = WAIT_LD;
    launch   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: if (bus.s_read) begin
        cnt_load = 1'b1;
        state_d  = (WAIT_CYCLES == 0) ? ACCEPT : WAIT;
      end
      WAIT: begin
        // initiator dropped the request before acceptance: abandon it
        if (!bus.s_read)   state_d = IDLE;
        else if (cnt_zero) state_d = ACCEPT;
      end
      ACCEPT: begin
        if (!bus.s_read) begin
          state_d = IDLE;
        end else if (bad_addr) begin
          state_d = RESP;
        end else begin
          launch   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = LAT_LD;
          state_d  = FETCH;
        end
      end
      FETCH: if (cnt_zero) begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_rden_q <= 1'b0;
      rdata_q    <= '0;
`ifdef FLASH_RESP_ADDR_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_rden_q <= launch;
      if (state_q == IDLE && bus.s_read) addr_q <= bus.s_address;
      if (launch)  mem_addr_q <= addr_q;
      if (capture) rdata_q    <= bus.mem_q;
`ifdef FLASH_RESP_ADDR_CHK_EN
      err_q <= (state_q == ACCEPT) && bus.s_read && bad_addr;
      if (state_q == ACCEPT && bus.s_read && bad_addr)
        rdata_q <= DATA_W'(FLASH_RESP_BAD_DATA);
`endif
    end
  end

  assign bus.s_waitrequest   = (state_q != ACCEPT);
  assign bus.s_readdatavalid = (state_q == RESP);
  assign bus.s_readdata      = rdata_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_rden        = mem_rden_q;

endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: two responders (defaults: WAIT=2/LAT=1 with
// MEM_DEPTH=1024, and WAIT=0/LAT=3) each behind a latency-accurate memory
// model. Directed table, hand sequences (back-to-back, reset in FETCH) and
// random single transactions checked against a transaction-level model.
// With FLASH_RESP_ADDR_CHK_EN defined, out-of-range reads are exercised too.
module tb_flash_read_responder;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam int WC [2] = '{2, 0};
  localparam int MC [2] = '{1, 3};

  logic inclk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  flash_resp_if #(.ADDR_W(23), .DATA_W(32)) ifa ();
  flash_resp_if #(.ADDR_W(23), .DATA_W(32)) ifb ();

`ifdef FLASH_RESP_ADDR_CHK_EN
  logic err_a, err_b;
`endif

  flash_read_responder #(.ADDR_W(23), .DATA_W(32), .WAIT_CYCLES(2), .MEM_LAT(1),
                         .MEM_DEPTH(1024)) u_a (
    .inclk (inclk), .reset (reset), .bus (ifa)
`ifdef FLASH_RESP_ADDR_CHK_EN
    , .rd_err (err_a)
`endif
  );

  flash_read_responder #(.ADDR_W(23), .DATA_W(32), .WAIT_CYCLES(0), .MEM_LAT(3)) u_b (
    .inclk (inclk), .reset (reset), .bus (ifb)
`ifdef FLASH_RESP_ADDR_CHK_EN
    , .rd_err (err_b)
`endif
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'h10) return 32'h1234_5678;
    return ({9'h0, a} * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // memory models: data appears MEM_LAT cycles after mem_rden, junk otherwise
  logic [31:0] pa;
  logic [31:0] pb [3];
  always @(posedge inclk) begin
    pa    <= ifa.mem_rden ? mem_word(ifa.mem_addr) : $urandom;
    pb[0] <= ifb.mem_rden ? mem_word(ifb.mem_addr) : $urandom;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ifa.mem_q = pa;
  assign ifb.mem_q = pb[2];

  typedef struct {
    logic        wr, rden, vld, err;
    logic [22:0] maddr;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    int          d;
    logic [22:0] adr;
    int          hold;
    int          acc;
    int          vld;
    bit          bad;
  } vec_t;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.wr = ifa.s_waitrequest; o.rden = ifa.mem_rden; o.vld = ifa.s_readdatavalid;
      o.maddr = ifa.mem_addr; o.data = ifa.s_readdata;
`ifdef FLASH_RESP_ADDR_CHK_EN
      o.err = err_a;
`else
      o.err = 1'b0;
`endif
    end else begin
      o.wr = ifb.s_waitrequest; o.rden = ifb.mem_rden; o.vld = ifb.s_readdatavalid;
      o.maddr = ifb.mem_addr; o.data = ifb.s_readdata;
`ifdef FLASH_RESP_ADDR_CHK_EN
      o.err = err_b;
`else
      o.err = 1'b0;
`endif
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int d, input logic rd, input logic [22:0] adr);
    if (d == 0) begin ifa.s_read = rd; ifa.s_address = adr; end
    else        begin ifb.s_read = rd; ifb.s_address = adr; end
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    obs_t o = get_obs(d);
    chk($sformatf("%s d%0d waitreq", tag, d), 64'(o.wr), 64'd1);
    chk($sformatf("%s d%0d valid/rden/err", tag, d), {61'd0, o.vld, o.rden, o.err}, 64'd0);
    chk($sformatf("%s d%0d readdata", tag, d), 64'(o.data), 64'd0);
    chk($sformatf("%s d%0d mem_addr", tag, d), 64'(o.maddr), 64'd0);
  endtask

  // One isolated transaction starting in IDLE, s_read held for `hold` cycles.
  // acc = cycle with waitrequest low (-1 none), vld = valid cycle (-1 none).
  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_txn(input int d, input logic [22:0] adr, input int hold,
                         input int acc, input int vld, input bit bad, input string tag);
    int   span = WC[d] + MC[d] + 5;
    obs_t o;
    logic [3:0] e;
    set_req(d, 1'b1, adr);
    for (int c = 0; c < span; c++) begin
      if (c == hold) set_req(d, 1'b0, adr);
      @(negedge inclk);
      o = get_obs(d);
      e = {c != acc, vld >= 0 && !bad && c == acc + 1, c == vld, bad && c == vld};
      chk($sformatf("%s c%0d {wr,rden,vld,err}", tag, c), 64'({o.wr, o.rden, o.vld, o.err}), 64'(e));
      if (e[2]) chk($sformatf("%s c%0d mem_addr", tag, c), 64'(o.maddr), 64'(adr));
      if (e[1]) chk($sformatf("%s c%0d readdata", tag, c), 64'(o.data),
                    64'(bad ? BAD : mem_word(adr)));
      @(posedge inclk); #1;
    end
  endtask

  vec_t tbl [$];

  initial begin
    obs_t o;
    reset = 1'b0;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);

    // reset state
    #2;
    chk_reset_vals(0, "rst");
    chk_reset_vals(1, "rst");
    repeat (2) @(posedge inclk);
    #1 reset = 1'b1;
    // idle with no request
    for (int c = 0; c < 3; c++) begin
      @(negedge inclk);
      for (int d = 0; d < 2; d++) begin
        o = get_obs(d);
        chk($sformatf("idle c%0d d%0d {wr,rden,vld}", c, d), 64'({o.wr, o.rden, o.vld}), 64'b100);
      end
    end
    @(posedge inclk); #1;

    // directed table
    tbl.push_back('{0, 23'h10,  4,  3,  6, 1'b0});  // single read, defaults
    tbl.push_back('{0, 23'h33,  1, -1, -1, 1'b0});  // dropped in first WAIT
    tbl.push_back('{0, 23'h44,  2, -1, -1, 1'b0});  // dropped in last WAIT
    tbl.push_back('{0, 23'h55,  3,  3, -1, 1'b0});  // dropped in ACCEPT
    tbl.push_back('{0, 23'h3FF, 4,  3,  6, 1'b0});  // last in-range word
    tbl.push_back('{1, 23'h20,  2,  1,  6, 1'b0});  // WAIT=0, LAT=3
    tbl.push_back('{1, 23'h21,  1,  1, -1, 1'b0});  // WAIT=0, dropped in ACCEPT
`ifdef FLASH_RESP_ADDR_CHK_EN
    tbl.push_back('{0, 23'd2000, 4, 3, 4, 1'b1});   // out of range
    tbl.push_back('{0, 23'd1024, 4, 3, 4, 1'b1});   // first out-of-range word
`else
    tbl.push_back('{0, 23'd2000, 4, 3, 6, 1'b0});
`endif
    foreach (tbl[i])
      run_txn(tbl[i].d, tbl[i].adr, tbl[i].hold, tbl[i].acc, tbl[i].vld, tbl[i].bad,
              $sformatf("vec%0d", i));

    // back-to-back with s_read held: valid at 6, 13, 20
    set_req(0, 1'b1, 23'h0);
    for (int c = 0; c < 23; c++) begin
      if (c == 7)  set_req(0, 1'b1, 23'h1);
      if (c == 14) set_req(0, 1'b1, 23'h2);
      if (c == 21) set_req(0, 1'b0, 23'h2);
      @(negedge inclk);
      o = get_obs(0);
      chk($sformatf("b2b c%0d {wr,vld}", c), 64'({o.wr, o.vld}),
          64'({!(c == 3 || c == 10 || c == 17), c == 6 || c == 13 || c == 20}));
      if (c == 6 || c == 13 || c == 20)
        chk($sformatf("b2b c%0d data", c), 64'(o.data), 64'(mem_word(23'((c - 6) / 7))));
      @(posedge inclk); #1;
    end

    // reset asserted in FETCH (cycle 4, mem_rden high)
    set_req(0, 1'b1, 23'h10);
    for (int c = 0; c < 4; c++) begin
      if (c == 4) set_req(0, 1'b0, 23'h10);
      @(posedge inclk); #1;
    end
    set_req(0, 1'b0, 23'h10);
    o = get_obs(0);
    chk("fetch pre-reset rden", 64'(o.rden), 64'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals(0, "mid-reset");
    @(posedge inclk); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge inclk);
      o = get_obs(0);
      chk($sformatf("post-reset c%0d {wr,rden,vld}", c), 64'({o.wr, o.rden, o.vld}), 64'b100);
      @(posedge inclk); #1;
    end

    // random transactions against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      int d, w, m, hold, acc, vld;
      logic [22:0] adr;
      bit bad;
      d    = int'($urandom_range(0, 1));
      w    = WC[d];
      m    = MC[d];
      hold = int'($urandom_range(1, w + 2));
      adr  = 23'($urandom);
      bad  = 1'b0;
`ifdef FLASH_RESP_ADDR_CHK_EN
      if (d == 0) begin
        adr = 23'($urandom_range(0, 2047));
        bad = (adr >= 23'd1024);
      end
`endif
      acc = (hold >= w + 1) ? w + 1 : -1;
      vld = (hold >= w + 2) ? (bad ? w + 2 : w + m + 3) : -1;
      run_txn(d, adr, hold, acc, vld, bad, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
